reduce_feeder: RTL

- Initiator side of the packed-vector reduction handshake (numbers / start / done / result) used by the FindMin reduction unit and its siblings in the attention datapath.
- On a command, reads NUM_WORDS words from a synchronous SRAM starting at a base address and packs them into the numbers bus.
- Then raises start, holds the vector stable until done, and captures result into a valid/ready response.
- Sits between the score SRAM and the reduction unit; replaces hand-driven stimulus.

---
 rtl/reduce_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/reduce_feeder.sv
// Initiator for the packed-vector reduction handshake: gathers NUM_WORDS SRAM words,
// drives numbers/start until done (or timeout), then returns the result on a valid/ready port.
module reduce_feeder #(
  parameter int WIDTH     = 16,
  parameter int NUM_WORDS = 8,
  parameter int AW        = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [AW-1:0]              cmd_base,
  output logic                       mem_en,
  output logic [AW-1:0]              mem_addr,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic [NUM_WORDS*WIDTH-1:0] numbers,
  output logic                       start,
  input  logic                       done,
  input  logic [WIDTH-1:0]           result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic                       res_err,
  output logic                       busy
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, REQ, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      numbers   <= '0;
      start     <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            numbers  <= '0;
            idx      <= '0;
            mem_en   <= 1'b1;
            mem_addr <= cmd_base;
            state    <= FETCH;
          end
        end
        FETCH: begin
          // Read data lags the address by one cycle, so word idx-1 lands here.
          if (idx != '0)
            numbers[(int'(idx) - 1) * WIDTH +: WIDTH] <= mem_rdata;
          if (idx == LAST) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          numbers[(NUM_WORDS - 1) * WIDTH +: WIDTH] <= mem_rdata;
          start    <= 1'b1;
          wait_cnt <= '0;
          state    <= REQ;
        end
        REQ: begin
          // done is tested first so it wins over a same-cycle timeout.
          if (done) begin
            res_data  <= result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            start     <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == TMAX) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            start     <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
